// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter.
// Contents: state encoding (IDLE/ISSUE/RESP, 3 is illegal), owner encoding
// (OWN_CPU/OWN_DBG) and the default address/data widths.
package mem_arb_pkg;

    localparam int unsigned DEF_AW = 8;
    localparam int unsigned DEF_DW = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t RESP  = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port synchronous memory.
// Every access runs accept (IDLE) -> ISSUE (strobe) -> RESP (ack), three cycles.
// Ties are settled round-robin on last_dbg; CPU wins the first tie after reset.
// Ports:
//   clock, reset              : clock and synchronous active-high reset
//   cpu_* / dbg_*             : req/we/addr/wdata in, ack pulse and rdata out per requester
//   mem_addr/wdata/re/we      : memory macro command side
//   mem_rdata                 : memory read data, valid the cycle after mem_re
//   ostate                    : current state for debug display
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    ostate
);

    state_t        state_q, state_d;
    logic          last_dbg_q;
    logic          owner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] cpu_rdata_q, dbg_rdata_q;

    logic accept;
    logic grant_dbg;
    logic resp_read;

    // Debug wins when alone, or on a tie when the CPU had the previous grant.
    assign grant_dbg = dbg_req & (~cpu_req | ~last_dbg_q);
    assign accept    = (state_q == IDLE) & (cpu_req | dbg_req);
    assign resp_read = (state_q == RESP) & ~we_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (cpu_req | dbg_req) ? ISSUE : IDLE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction latches and per-requester read data
    always_ff @(posedge clock) begin
        if (reset) begin
            last_dbg_q  <= 1'b1;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (accept) begin
                owner_q    <= grant_dbg ? OWN_DBG : OWN_CPU;
                last_dbg_q <= grant_dbg;
                we_q       <= grant_dbg ? dbg_we    : cpu_we;
                addr_q     <= grant_dbg ? dbg_addr  : cpu_addr;
                wdata_q    <= grant_dbg ? dbg_wdata : cpu_wdata;
            end
            if (resp_read && owner_q == OWN_CPU) cpu_rdata_q <= mem_rdata;
            if (resp_read && owner_q == OWN_DBG) dbg_rdata_q <= mem_rdata;
        end
    end

    // Outputs, decoded from registered state only. Read data is forwarded
    // from the memory during RESP so it is valid together with ack.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        cpu_ack   = 1'b0;
        dbg_ack   = 1'b0;
        cpu_rdata = cpu_rdata_q;
        dbg_rdata = dbg_rdata_q;
        ostate    = state_q;
        case (state_q)
            ISSUE: begin
                mem_we = we_q;
                mem_re = ~we_q;
            end
            RESP: begin
                cpu_ack = (owner_q == OWN_CPU);
                dbg_ack = (owner_q == OWN_DBG);
                if (!we_q && owner_q == OWN_CPU) cpu_rdata = mem_rdata;
                if (!we_q && owner_q == OWN_DBG) dbg_rdata = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule
